x_uart_rx_cmd: RTL and testbench
================================

// Module: x_uart_rx_cmd
// PURPOSE
//  UART receiver (8N1) that turns the host serial line into 8-bit command bytes for the x_byte_des command deserialiser.
//  Holds each received byte in a one-entry output buffer under a valid/accept handshake.
//  Flags bytes dropped because of a framing error or because the buffer was still full (overrun).
// PARAMETERS
//  CLKS_PER_BIT  104  i_clk cycles per UART bit (12 MHz / 115200); legal range >= 4
//  SYNC_STAGES   2    metastability flops on i_rx; legal range >= 2
// PORTS
//  i_clk        in   1  single clock; all state on posedge
//  i_nrst       in   1  reset, asynchronous assert, active-low
//  i_rx         in   1  asynchronous serial input; idles high
//  o_valid      out  1  o_cmd holds an unconsumed byte
//  i_accept     in   1  consumer takes the byte when o_valid & i_accept
//  o_cmd        out  8  received byte; LSB is received first
//  o_frame_err  out  1  one-cycle pulse: stop bit sampled low, byte discarded
//  o_overrun    out  1  one-cycle pulse: new byte arrived while buffer full and not accepted, new byte discarded
// BEHAVIOUR
//  Reset (i_nrst=0): state IDLE; synchroniser flops=1; o_valid=0, o_cmd=0, o_frame_err=0, o_overrun=0.
//   Reset mid-frame abandons the frame. It discards any buffered byte without pulsing an error.
//  rx_s = i_rx after SYNC_STAGES flops. All decisions below use rx_s only.
//  Bit timer: counts 0..CLKS_PER_BIT-1 and wraps; bit index counts 0..7.
//  State IDLE
//   - rx_s==0 -> START, timer cleared.
//  State START
//   - When timer reaches CLKS_PER_BIT/2-1 (mid start bit):
//     - rx_s==1 -> glitch, back to IDLE, no flags;
//     - else -> DATA, timer cleared, bit index=0.
//  State DATA
//   - Each time timer reaches CLKS_PER_BIT-1 (mid-bit), shift rx_s into shift[7] and shift right.
//   - After bit index 7 is sampled -> STOP.
//  State STOP
//   - At the next mid-bit sample:
//     - rx_s==1 -> byte complete, go to IDLE;
//     - rx_s==0 -> o_frame_err pulse, byte dropped, go to BREAK.
//  State BREAK
//   - Wait for rx_s==1 -> IDLE. Prevents a held-low line re-triggering START.
//  Output buffer, evaluated each cycle; "complete" = STOP sample with rx_s==1:
//   - o_valid & i_accept & !complete -> o_valid=0 next cycle.
//   - complete & (!o_valid | i_accept) -> o_cmd<=shift, o_valid=1 next cycle. A same-cycle accept and new byte is lossless.
//   - complete & o_valid & !i_accept -> o_overrun pulse; o_cmd and o_valid unchanged.
//   - o_cmd is stable whenever o_valid=1 and not accepted.
//   - i_accept while o_valid=0 is ignored.
//  Latency: o_valid rises 1 cycle after the mid-stop-bit sample, which is about 9.5 bit times + SYNC_STAGES + 1 cycles after the falling start edge.
//  Back-to-back frames: the receiver is ready in IDLE by mid-stop bit, so a start edge half a bit later is caught.
//  Error pulses are mutually exclusive per frame and never overlap o_valid changes for the dropped byte.
// STRUCTURE
//  x_uart_pkg:
//   - typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} uart_rx_state_t;
//   - localparam UART_DATA_BITS=8.
//  Sub-module x_sync (SYNC_STAGES-deep flop chain; reset value parameter, here 1). It is reused for any other async input.
//  Timer width = $clog2(CLKS_PER_BIT). The main FSM, shift register and output buffer are in this module.
// TESTING (bench CLKS_PER_BIT=8, drive i_rx with ideal 8N1 frames)
//  1. Frame 0x21 with i_accept=1 -> one o_valid pulse with o_cmd=0x21; no error pulses.
//  2. Frames 0x01,0x15,0x2F back-to-back (no idle gap), i_accept=0 until all sent.
//     - Expect o_cmd=0x01 held, and two o_overrun pulses.
//     - Then accept -> o_valid drops.
//  3. Frame 0xA5 with stop bit forced 0 for 2 bits, then line high, then 0x3C:
//     - o_frame_err pulses once, no o_valid for 0xA5;
//     - 0x3C is received correctly.
//  4. 3-cycle low glitch on idle i_rx -> no state exit beyond START, no o_valid, no flags.
//  5. Buffer holds 0x10 and i_accept asserts exactly in the completion cycle of 0x11:
//     - expect o_cmd=0x11, o_valid stays 1, no o_overrun.
//  6. Drop i_nrst during DATA bit 4 for 3 cycles, then send 0x20:
//     - outputs all 0 during reset;
//     - next o_cmd=0x20 with no spurious byte or error.

Source files
------------

// File: rtl/x_uart_pkg.sv
// Shared types and constants for the UART command receiver.
package x_uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} uart_rx_state_t;

  localparam int UART_DATA_BITS = 8;

endpackage

// File: rtl/x_sync.sv
// Flop chain that brings an asynchronous input into the clk domain.
module x_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_reg <= {STAGES{RESET_VAL}};
    end else begin
      chain_reg <= {chain_reg[STAGES-2:0], d};
    end
  end

  assign q = chain_reg[STAGES-1];

endmodule

// File: rtl/x_uart_rx_cmd.sv
// 8N1 UART receiver feeding a one-entry command buffer with valid/accept,
// flagging frames lost to framing errors or buffer overrun.
module x_uart_rx_cmd #(
  parameter int CLKS_PER_BIT = 104,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       i_clk,
  input  logic       i_nrst,
  input  logic       i_rx,
  output logic       o_valid,
  input  logic       i_accept,
  output logic [7:0] o_cmd,
  output logic       o_frame_err,
  output logic       o_overrun
);
  import x_uart_pkg::*;

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(UART_DATA_BITS);
  localparam logic [TW-1:0] T_LAST   = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_MID    = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(UART_DATA_BITS - 1);

  logic rx_s;

  uart_rx_state_t             state_reg, state_next;
  logic [TW-1:0]              timer_reg, timer_next;
  logic [IW-1:0]              bit_idx_reg, bit_idx_next;
  logic [UART_DATA_BITS-1:0]  shift_reg, shift_next;
  logic [UART_DATA_BITS-1:0]  cmd_reg, cmd_next;
  logic                       valid_reg, valid_next;
  logic                       frame_err_reg, frame_err_next;
  logic                       overrun_reg, overrun_next;
  logic                       complete;

  x_sync #(
    .STAGES   (SYNC_STAGES),
    .RESET_VAL(1'b1)
  ) u_rx_sync (
    .clk  (i_clk),
    .rst_n(i_nrst),
    .d    (i_rx),
    .q    (rx_s)
  );

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_reg     <= IDLE;
      timer_reg     <= '0;
      bit_idx_reg   <= '0;
      shift_reg     <= '0;
      cmd_reg       <= '0;
      valid_reg     <= 1'b0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      timer_reg     <= timer_next;
      bit_idx_reg   <= bit_idx_next;
      shift_reg     <= shift_next;
      cmd_reg       <= cmd_next;
      valid_reg     <= valid_next;
      frame_err_reg <= frame_err_next;
      overrun_reg   <= overrun_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    timer_next     = (timer_reg == T_LAST) ? '0 : timer_reg + TW'(1);
    bit_idx_next   = bit_idx_reg;
    shift_next     = shift_reg;
    cmd_next       = cmd_reg;
    valid_next     = valid_reg;
    frame_err_next = 1'b0;
    overrun_next   = 1'b0;
    complete       = 1'b0;

    case (state_reg)
      IDLE: begin
        timer_next = '0;
        if (!rx_s) state_next = START;
      end
      START: begin
        if (timer_reg == T_MID) begin
          if (rx_s) begin
            state_next = IDLE;
          end else begin
            state_next   = DATA;
            timer_next   = '0;
            bit_idx_next = '0;
          end
        end
      end
      DATA: begin
        if (timer_reg == T_LAST) begin
          shift_next = {rx_s, shift_reg[UART_DATA_BITS-1:1]};
          if (bit_idx_reg == IDX_LAST) state_next = STOP;
          else bit_idx_next = bit_idx_reg + IW'(1);
        end
      end
      STOP: begin
        if (timer_reg == T_LAST) begin
          if (rx_s) begin
            complete   = 1'b1;
            state_next = IDLE;
          end else begin
            frame_err_next = 1'b1;
            state_next     = BREAK;
          end
        end
      end
      BREAK: begin
        // Hold here until the line returns high so a stuck-low line cannot restart a frame.
        if (rx_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (complete) begin
      if (!valid_reg || i_accept) begin
        cmd_next   = shift_reg;
        valid_next = 1'b1;
      end else begin
        overrun_next = 1'b1;
      end
    end else if (valid_reg && i_accept) begin
      valid_next = 1'b0;
    end
  end

  assign o_valid     = valid_reg;
  assign o_cmd       = cmd_reg;
  assign o_frame_err = frame_err_reg;
  assign o_overrun   = overrun_reg;

endmodule

// File: tb/tb_x_uart_rx_cmd.sv
// Directed self-checking bench for x_uart_rx_cmd with 8 clocks per bit.
module tb_x_uart_rx_cmd;
  import x_uart_pkg::*;

  localparam int CPB = 8;

  logic       i_clk = 1'b0;
  logic       i_nrst = 1'b0;
  logic       i_rx = 1'b1;
  logic       i_accept = 1'b0;
  logic       o_valid;
  logic [7:0] o_cmd;
  logic       o_frame_err;
  logic       o_overrun;

  int n_assert = 0;
  int n_fail   = 0;

  int n_rise = 0, n_fall = 0, n_ferr = 0, n_ovr = 0, n_start_cyc = 0, n_data_cyc = 0;
  logic       prev_valid = 1'b0;
  logic [7:0] last_cmd = 8'h00;
  int r0, f0, e0, o0, s0, d0;

  always #5 i_clk = ~i_clk;

  x_uart_rx_cmd #(
    .CLKS_PER_BIT(CPB),
    .SYNC_STAGES (2)
  ) dut (
    .i_clk      (i_clk),
    .i_nrst     (i_nrst),
    .i_rx       (i_rx),
    .o_valid    (o_valid),
    .i_accept   (i_accept),
    .o_cmd      (o_cmd),
    .o_frame_err(o_frame_err),
    .o_overrun  (o_overrun)
  );

  // Event counters sampled mid-cycle, away from the active edge.
  always @(negedge i_clk) begin
    if (o_valid && !prev_valid) begin
      n_rise++;
      last_cmd = o_cmd;
    end
    if (!o_valid && prev_valid) n_fall++;
    if (o_frame_err) n_ferr++;
    if (o_overrun) n_ovr++;
    if (dut.state_reg == START) n_start_cyc++;
    if (dut.state_reg == DATA) n_data_cyc++;
    prev_valid = o_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    n_assert++;
    assert (obs === expd) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expd);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic snap();
    r0 = n_rise; f0 = n_fall; e0 = n_ferr; o0 = n_ovr; s0 = n_start_cyc; d0 = n_data_cyc;
  endtask

  // Ideal 8N1 frame; acc_pulse raises i_accept for exactly the completion cycle.
  task automatic send_frame(input logic [7:0] b, input logic stop_val, input logic acc_pulse);
    i_rx = 1'b0;
    tick(CPB);
    for (int j = 0; j < 8; j++) begin
      i_rx = b[j];
      tick(CPB);
    end
    i_rx = stop_val;
    for (int c = 0; c < CPB; c++) begin
      tick(1);
      if (acc_pulse && c == 5) i_accept = 1'b1;
      if (acc_pulse && c == 6) i_accept = 1'b0;
    end
  endtask

  initial begin
    tick(3);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_cmd", 32'(o_cmd), 32'h00);
    check("rst_ferr", 32'(o_frame_err), 32'd0);
    check("rst_ovr", 32'(o_overrun), 32'd0);
    i_nrst = 1'b1;
    tick(2 * CPB);

    // Single frame, consumer always ready
    i_accept = 1'b1;
    snap();
    send_frame(8'h21, 1'b1, 1'b0);
    tick(CPB);
    i_accept = 1'b0;
    check("t1_rise", 32'(n_rise - r0), 32'd1);
    check("t1_cmd", 32'(last_cmd), 32'h21);
    check("t1_ferr", 32'(n_ferr - e0), 32'd0);
    check("t1_ovr", 32'(n_ovr - o0), 32'd0);
    check("t1_valid_low", 32'(o_valid), 32'd0);

    // Back-to-back frames with consumer stalled
    snap();
    send_frame(8'h01, 1'b1, 1'b0);
    send_frame(8'h15, 1'b1, 1'b0);
    send_frame(8'h2F, 1'b1, 1'b0);
    tick(CPB);
    check("t2_rise", 32'(n_rise - r0), 32'd1);
    check("t2_cmd", 32'(o_cmd), 32'h01);
    check("t2_valid", 32'(o_valid), 32'd1);
    check("t2_ovr", 32'(n_ovr - o0), 32'd2);
    check("t2_ferr", 32'(n_ferr - e0), 32'd0);
    i_accept = 1'b1;
    tick(1);
    i_accept = 1'b0;
    tick(1);
    check("t2_valid_drop", 32'(o_valid), 32'd0);

    // Framing error with stop held low, then a good frame
    i_accept = 1'b1;
    snap();
    send_frame(8'hA5, 1'b0, 1'b0);
    i_rx = 1'b0;
    tick(CPB);
    i_rx = 1'b1;
    tick(2 * CPB);
    send_frame(8'h3C, 1'b1, 1'b0);
    tick(CPB);
    i_accept = 1'b0;
    check("t3_ferr", 32'(n_ferr - e0), 32'd1);
    check("t3_rise", 32'(n_rise - r0), 32'd1);
    check("t3_cmd", 32'(last_cmd), 32'h3C);
    check("t3_ovr", 32'(n_ovr - o0), 32'd0);

    // Short low glitch on an idle line
    snap();
    i_rx = 1'b0;
    tick(3);
    i_rx = 1'b1;
    tick(3 * CPB);
    check("t4_start_cycles", 32'(n_start_cyc - s0), 32'(CPB / 2));
    check("t4_data_cycles", 32'(n_data_cyc - d0), 32'd0);
    check("t4_rise", 32'(n_rise - r0), 32'd0);
    check("t4_ferr", 32'(n_ferr - e0), 32'd0);
    check("t4_ovr", 32'(n_ovr - o0), 32'd0);
    check("t4_state", 32'(dut.state_reg), 32'(IDLE));

    // Accept lands in the same cycle a new byte completes
    snap();
    send_frame(8'h10, 1'b1, 1'b0);
    check("t5_valid_first", 32'(o_valid), 32'd1);
    check("t5_cmd_first", 32'(o_cmd), 32'h10);
    send_frame(8'h11, 1'b1, 1'b1);
    tick(4);
    check("t5_ovr", 32'(n_ovr - o0), 32'd0);
    check("t5_valid", 32'(o_valid), 32'd1);
    check("t5_cmd", 32'(o_cmd), 32'h11);
    check("t5_fall", 32'(n_fall - f0), 32'd0);

    // Reset in the middle of data bit 4 while a byte is buffered
    i_rx = 1'b0;
    tick(CPB);
    for (int j = 0; j < 4; j++) begin
      i_rx = 1'b0;
      tick(CPB);
    end
    i_rx = 1'b0;
    tick(CPB / 2);
    check("t6_pre_state", 32'(dut.state_reg), 32'(DATA));
    i_nrst = 1'b0;
    #1;
    check("t6_rst_valid", 32'(o_valid), 32'd0);
    check("t6_rst_cmd", 32'(o_cmd), 32'h00);
    check("t6_rst_ferr", 32'(o_frame_err), 32'd0);
    check("t6_rst_ovr", 32'(o_overrun), 32'd0);
    check("t6_rst_state", 32'(dut.state_reg), 32'(IDLE));
    tick(3);
    i_rx = 1'b1;
    i_nrst = 1'b1;
    tick(2 * CPB);
    snap();
    i_accept = 1'b1;
    send_frame(8'h20, 1'b1, 1'b0);
    tick(CPB);
    i_accept = 1'b0;
    check("t6_rise", 32'(n_rise - r0), 32'd1);
    check("t6_cmd", 32'(last_cmd), 32'h20);
    check("t6_ferr", 32'(n_ferr - e0), 32'd0);
    check("t6_ovr", 32'(n_ovr - o0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
